// File: rtl/accel_core_pkg.sv
// Shared types and constants for the accelerator core register map.
// Holds the register index enum, AXI response codes and the mmap FSM state types.
package accel_core_pkg;

  localparam int unsigned MMAP_WIDTH = 32;

  // Indices 4..7 are status registers, written by the core and read-only to the host.
  typedef enum logic [3:0] {
    RegCtrl, RegCfg0, RegCfg1, RegCfg2,
    RegStatus, RegResult0, RegResult1, RegErr,
    RegScratch0, RegScratch1, RegScratch2, RegScratch3,
    RegScratch4, RegScratch5, RegScratch6, RegScratch7
  } mmap_addr_e;

  localparam logic [15:0] RO_MASK_DEFAULT = 16'h00F0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WWaitW, WWaitAw, WResp} wr_state_e;
  typedef enum logic {RIdle, RData} rd_state_e;

endpackage

// File: rtl/accel_mmap_wr_join.sv
// Joins the AXI4-Lite AW and W channels into a single-cycle commit strobe and
// drives the B channel; one write in flight at a time.
module accel_mmap_wr_join
  import accel_core_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [MMAP_WIDTH-1:0] s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic                  commit_en,
  output logic [IDX_W-1:0]      commit_idx,
  output logic [MMAP_WIDTH-1:0] commit_data,
  output logic [3:0]            commit_strb
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam logic [WORD_W:0] NUM_REGS_W = (WORD_W + 1)'(NUM_REGS);

  wr_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [MMAP_WIDTH-1:0] data_q;
  logic [3:0]            strb_q;
  logic [1:0]            bresp_q;
  logic                  latch_aw, latch_w, commit;
  logic [ADDR_W-1:0]     cm_addr;
  logic [WORD_W-1:0]     cm_word;
  logic                  cm_in_range;
  logic                  unused_addr_lsb;

  // Commit uses whichever half arrives live this cycle and the latched copy of the other.
  always_comb begin
    state_d     = state_q;
    s_awready   = 1'b0;
    s_wready    = 1'b0;
    s_bvalid    = 1'b0;
    latch_aw    = 1'b0;
    latch_w     = 1'b0;
    commit      = 1'b0;
    cm_addr     = addr_q;
    commit_data = data_q;
    commit_strb = strb_q;
    case (state_q)
      WIdle: begin
        s_awready   = 1'b1;
        s_wready    = 1'b1;
        cm_addr     = s_awaddr;
        commit_data = s_wdata;
        commit_strb = s_wstrb;
        if (s_awvalid && s_wvalid) begin
          commit  = 1'b1;
          state_d = WResp;
        end else if (s_awvalid) begin
          latch_aw = 1'b1;
          state_d  = WWaitW;
        end else if (s_wvalid) begin
          latch_w = 1'b1;
          state_d = WWaitAw;
        end
      end
      WWaitW: begin
        s_wready    = 1'b1;
        commit_data = s_wdata;
        commit_strb = s_wstrb;
        if (s_wvalid) begin
          commit  = 1'b1;
          state_d = WResp;
        end
      end
      WWaitAw: begin
        s_awready = 1'b1;
        cm_addr   = s_awaddr;
        if (s_awvalid) begin
          commit  = 1'b1;
          state_d = WResp;
        end
      end
      WResp: begin
        s_bvalid = 1'b1;
        if (s_bready) state_d = WIdle;
      end
      default: state_d = WIdle;
    endcase
  end

  assign cm_word         = cm_addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^cm_addr[1:0];
  assign cm_in_range     = {1'b0, cm_word} < NUM_REGS_W;
  assign commit_en       = commit && cm_in_range;
  assign commit_idx      = cm_word[IDX_W-1:0];
  assign s_bresp         = bresp_q;

  always_ff @(posedge mem_clk or negedge mem_rst) begin
    if (!mem_rst) begin
      state_q <= WIdle;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (latch_aw) addr_q <= s_awaddr;
      if (latch_w) begin
        data_q <= s_wdata;
        strb_q <= s_wstrb;
      end
      if (commit) bresp_q <= cm_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: rtl/accel_mmap_regs.sv
// AXI4-Lite responder owning the accelerator mmap register array; host writes
// RW registers, the core writes status (RO) registers. Byte strobes honoured with MMAP_WSTRB_EN.
module accel_mmap_regs
  import accel_core_pkg::*;
#(
  parameter int unsigned           NUM_REGS = 16,
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK  = RO_MASK_DEFAULT,
  localparam int unsigned          IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                                 mem_clk,
  input  logic                                 mem_rst,
  input  logic [ADDR_W-1:0]                    s_awaddr,
  input  logic                                 s_awvalid,
  output logic                                 s_awready,
  input  logic [MMAP_WIDTH-1:0]                s_wdata,
  input  logic [3:0]                           s_wstrb,
  input  logic                                 s_wvalid,
  output logic                                 s_wready,
  output logic [1:0]                           s_bresp,
  output logic                                 s_bvalid,
  input  logic                                 s_bready,
  input  logic [ADDR_W-1:0]                    s_araddr,
  input  logic                                 s_arvalid,
  output logic                                 s_arready,
  output logic [MMAP_WIDTH-1:0]                s_rdata,
  output logic [1:0]                           s_rresp,
  output logic                                 s_rvalid,
  input  logic                                 s_rready,
  input  logic                                 core_wr_en,
  input  logic [IDX_W-1:0]                     core_wr_addr,
  input  logic [MMAP_WIDTH-1:0]                core_wr_data,
  output logic [NUM_REGS-1:0][MMAP_WIDTH-1:0]  mmap
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam logic [WORD_W:0] NUM_REGS_W = (WORD_W + 1)'(NUM_REGS);

  logic [NUM_REGS-1:0][MMAP_WIDTH-1:0] mmap_q, mmap_d;
  logic                  commit_en;
  logic [IDX_W-1:0]      commit_idx;
  logic [MMAP_WIDTH-1:0] commit_data, wmask;
  logic [3:0]            commit_strb;

  accel_mmap_wr_join #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_wr_join (
    .mem_clk     (mem_clk),
    .mem_rst     (mem_rst),
    .s_awaddr    (s_awaddr),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

`ifdef MMAP_WSTRB_EN
  always_comb begin
    wmask = '0;
    for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{commit_strb[k]}};
  end
`else
  logic unused_strb;
  assign unused_strb = ^commit_strb;
  assign wmask       = '1;
`endif

  // Host commits only land on RW registers, core writes only on RO ones.
  always_comb begin
    mmap_d = mmap_q;
    if (commit_en && !RO_MASK[commit_idx]) begin
      mmap_d[commit_idx] = (mmap_q[commit_idx] & ~wmask) | (commit_data & wmask);
    end
    if (core_wr_en && RO_MASK[core_wr_addr]) mmap_d[core_wr_addr] = core_wr_data;
  end

  always_ff @(posedge mem_clk or negedge mem_rst) begin
    if (!mem_rst) mmap_q <= '0;
    else          mmap_q <= mmap_d;
  end

  assign mmap = mmap_q;

  rd_state_e             rd_q, rd_d;
  logic [MMAP_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [WORD_W-1:0]     rd_word;
  logic                  rd_in_range, ar_hs;
  logic                  unused_araddr_lsb;

  assign rd_word           = s_araddr[ADDR_W-1:2];
  assign unused_araddr_lsb = ^s_araddr[1:0];
  assign rd_in_range       = {1'b0, rd_word} < NUM_REGS_W;
  assign ar_hs             = s_arvalid && s_arready;

  always_comb begin
    rd_d      = rd_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    case (rd_q)
      RIdle: begin
        s_arready = 1'b1;
        if (s_arvalid) rd_d = RData;
      end
      RData: begin
        s_rvalid = 1'b1;
        if (s_rready) rd_d = RIdle;
      end
      default: rd_d = RIdle;
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_rst) begin
    if (!mem_rst) begin
      rd_q    <= RIdle;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rd_q <= rd_d;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? mmap_q[rd_word[IDX_W-1:0]] : '0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_rdata = rdata_q;
  assign s_rresp = rresp_q;

endmodule

// File: tb/tb_accel_mmap_regs.sv
// Randomized bench for accel_mmap_regs against an array-level register model;
// define MMAP_WSTRB_EN to match a strobe-enabled build.
module tb_accel_mmap_regs;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 8;
  localparam logic [15:0] RO       = 16'h00F0;

  logic        mem_clk = 1'b0;
  logic        mem_rst;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        core_wr_en;
  logic [3:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic [NUM_REGS-1:0][31:0] mmap;

  accel_mmap_regs #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .RO_MASK  (RO)
  ) dut (
    .mem_clk      (mem_clk),
    .mem_rst      (mem_rst),
    .s_awaddr     (s_awaddr),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_araddr     (s_araddr),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .core_wr_en   (core_wr_en),
    .core_wr_addr (core_wr_addr),
    .core_wr_data (core_wr_data),
    .mmap         (mmap)
  );

  always #5 mem_clk = ~mem_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model [NUM_REGS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
`ifdef MMAP_WSTRB_EN
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`else
    return 32'hFFFF_FFFF;
`endif
  endfunction

  task automatic check_mmap(input string tag);
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("%s[%0d]", tag, i), mmap[i], model[i]);
  endtask

  // Issue one write; AW and W start after independent delays, B accepted after b_dly cycles.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int   idx;
    bit   aw_done, w_done;
    logic [31:0] m;
    idx     = int'(addr) / 4;
    aw_done = 0;
    w_done  = 0;
    s_awaddr = addr;
    s_wdata  = data;
    s_wstrb  = strb;
    fork
      begin
        bit hs;
        hs = 0;
        for (int c = 0; c < aw_dly; c++) begin
          tick();
          if (w_done) check("wready_low_waiting_aw", 32'(s_wready), 32'd0);
        end
        s_awvalid = 1;
        for (int c = 0; c < 20 && !hs; c++) begin
          hs = s_awready;
          tick();
        end
        s_awvalid = 0;
        aw_done   = 1;
        if (!hs) check("aw_timeout", 32'd0, 32'd1);
      end
      begin
        bit hs;
        hs = 0;
        for (int c = 0; c < w_dly; c++) begin
          tick();
          if (aw_done) check("awready_low_waiting_w", 32'(s_awready), 32'd0);
        end
        s_wvalid = 1;
        for (int c = 0; c < 20 && !hs; c++) begin
          hs = s_wready;
          tick();
        end
        s_wvalid = 0;
        w_done   = 1;
        if (!hs) check("w_timeout", 32'd0, 32'd1);
      end
    join
    if (idx < NUM_REGS && !RO[idx]) begin
      m          = byte_mask(strb);
      model[idx] = (model[idx] & ~m) | (data & m);
    end
    check("bvalid_latency", 32'(s_bvalid), 32'd1);
    check("aw_w_blocked_in_resp", 32'({s_awready, s_wready}), 32'd0);
    check_mmap("wr_commit");
    for (int c = 0; c < b_dly; c++) begin
      tick();
      check("bvalid_hold", 32'(s_bvalid), 32'd1);
    end
    check("bresp", 32'(s_bresp), (idx < NUM_REGS) ? 32'd0 : 32'd2);
    s_bready = 1;
    tick();
    s_bready = 0;
    check("bvalid_clear", 32'(s_bvalid), 32'd0);
    check("ready_after_b", 32'({s_awready, s_wready}), 32'd3);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int rr_dly);
    int   idx;
    bit   hs;
    logic [31:0] exp;
    idx = int'(addr) / 4;
    exp = (idx < NUM_REGS) ? model[idx] : 32'd0;
    hs  = 0;
    s_araddr  = addr;
    s_arvalid = 1;
    for (int c = 0; c < 20 && !hs; c++) begin
      hs = s_arready;
      tick();
    end
    s_arvalid = 0;
    if (!hs) check("ar_timeout", 32'd0, 32'd1);
    check("rvalid_latency", 32'(s_rvalid), 32'd1);
    for (int c = 0; c <= rr_dly; c++) begin
      check("rdata", s_rdata, exp);
      check("rresp", 32'(s_rresp), (idx < NUM_REGS) ? 32'd0 : 32'd2);
      check("arready_low_in_rdata", 32'(s_arready), 32'd0);
      if (c < rr_dly) begin
        tick();
        check("rvalid_hold", 32'(s_rvalid), 32'd1);
      end
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    check("rvalid_clear", 32'(s_rvalid), 32'd0);
    check("arready_after_r", 32'(s_arready), 32'd1);
  endtask

  task automatic core_write(input logic [3:0] idx, input logic [31:0] data);
    core_wr_en   = 1;
    core_wr_addr = idx;
    core_wr_data = data;
    tick();
    core_wr_en = 0;
    if (RO[idx]) model[idx] = data;
    check_mmap("core_wr");
  endtask

  initial begin
    mem_rst      = 0;
    s_awaddr     = '0;
    s_awvalid    = 0;
    s_wdata      = '0;
    s_wstrb      = '0;
    s_wvalid     = 0;
    s_bready     = 0;
    s_araddr     = '0;
    s_arvalid    = 0;
    s_rready     = 0;
    core_wr_en   = 0;
    core_wr_addr = '0;
    core_wr_data = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    repeat (2) tick();
    check("rst_readies", 32'({s_awready, s_wready, s_arready}), 32'd7);
    check("rst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
    check("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check_mmap("rst_mmap");
    mem_rst = 1;
    tick();

    axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_write(8'h08, 32'h1234_5678, 4'hF, 3, 0, 0);
    axi_write(8'h0C, 32'hCAFE_0001, 4'hF, 0, 2, 1);
    axi_read(8'h04, 5);
    axi_read(8'h09, 0);

    core_write(4'd4, 32'h1);
    axi_write(8'h10, 32'h0000_FFFF, 4'hF, 0, 0, 0);
    check("ro_kept", mmap[4], 32'h1);
    core_write(4'd1, 32'h5555_5555);
    check("core_rw_ignored", mmap[1], 32'hDEAD_BEEF);

    axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 2);
    axi_read(8'h40, 1);

    // Abandon a write after AW only, then reset asynchronously.
    s_awaddr  = 8'h0C;
    s_awvalid = 1;
    tick();
    s_awvalid = 0;
    check("aw_only_blocks_aw", 32'(s_awready), 32'd0);
    #2 mem_rst = 0;
    #1;
    check("midrst_readies", 32'({s_awready, s_wready, s_arready}), 32'd7);
    check("midrst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check_mmap("midrst_mmap");
    #2 mem_rst = 1;
    tick();
    tick();
    check("post_rst_bvalid", 32'(s_bvalid), 32'd0);

    axi_write(8'h00, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
`ifdef MMAP_WSTRB_EN
    check("wstrb_byte1", mmap[0], 32'h0000_CC00);
    axi_write(8'h00, 32'h1111_1111, 4'b0000, 0, 0, 0);
    check("wstrb_none", mmap[0], 32'h0000_CC00);
`endif

    for (int it = 0; it < 80; it++) begin
      int unsigned op, idx;
      op  = $urandom_range(0, 2);
      idx = $urandom_range(0, 17);
      case (op)
        0: axi_write(8'(idx * 4 + $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
        1: axi_read(8'(idx * 4 + $urandom_range(0, 3)), int'($urandom_range(0, 3)));
        default: core_write(4'(idx), $urandom);
      endcase
    end
    check_mmap("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
